regbus2axi4lite: RTL and testbench

Bridge that converts single register-bus (regbus) accesses into AXI4-lite master transactions, one outstanding access at a time. It is the initiator counterpart of the AXI4-lite-to-regbus slave bridge. It lets an on-chip controller or sequencer read and write any AXI4-lite register block, including the miner's own control/address/length registers in bench loopback. Responses are returned to the requester as a one-cycle ready pulse with read data and an error flag.

---
 rtl/soc_miner_pkg.sv | 25 ++
 rtl/regbus2axi4lite.sv | 252 +++++++++++++++++++++++++
 tb/tb_regbus2axi4lite.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_miner_pkg.sv
// soc_miner_pkg
// Shared definitions for the miner SoC blocks. Holds the regbus-to-AXI4-lite
// bridge state encoding, the AXI OKAY response code and a small helper that
// classifies AXI responses.
package soc_miner_pkg;

  // AXI response code for a successful access.
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Bridge FSM states.
  typedef enum logic [2:0] {
    RB2AXI_IDLE    = 3'd0,
    RB2AXI_WR_REQ  = 3'd1,
    RB2AXI_WR_RESP = 3'd2,
    RB2AXI_RD_REQ  = 3'd3,
    RB2AXI_RD_RESP = 3'd4,
    RB2AXI_DONE    = 3'd5
  } rb2axi_state_e;

  // Any response other than OKAY (SLVERR, DECERR, EXOKAY) is reported as an error.
  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage : soc_miner_pkg

// File: rtl/regbus2axi4lite.sv
// regbus2axi4lite
// Converts single regbus accesses into AXI4-lite master transactions, one
// outstanding access at a time. Completion is signalled by a one-cycle
// reg_ready pulse carrying reg_rdata (reads) and reg_err (non-OKAY response).
//
// Ports:
//   Clk, RESET                 clock, synchronous active-high reset
//   reg_addr_valid/reg_write   request strobe and direction (held until reg_ready)
//   reg_addr/reg_wdata         request byte address and write data
//   reg_rdata/reg_ready/reg_err  completion data, pulse and error flag
//   m_aw*/m_w*/m_b*            AXI4-lite write address, data and response channels
//   m_ar*/m_r*                 AXI4-lite read address and data channels
//
// All outputs come straight from flops (or are constants).
module regbus2axi4lite
  import soc_miner_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    RESET,
  // regbus side
  input  logic                    reg_addr_valid,
  input  logic                    reg_write,
  input  logic [ADDR_WIDTH-1:0]   reg_addr,
  input  logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH-1:0]   reg_rdata,
  output logic                    reg_ready,
  output logic                    reg_err,
  // AXI4-lite write address
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  // AXI4-lite write data
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  // AXI4-lite write response
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  // AXI4-lite read address
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  // AXI4-lite read data
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp
);

  // Byte-lane bits of the address are dropped so every access is word aligned.
  localparam int unsigned LANE_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << LANE_BITS;

  rb2axi_state_e         state_q,   state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q,  w_done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  bready_q,  bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q,  rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                  err_q,     err_d;
  logic                  ready_q,   ready_d;

  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic ar_hs_s;
  logic r_hs_s;

  assign aw_hs_s = awvalid_q & m_awready;
  assign w_hs_s  = wvalid_q  & m_wready;
  assign b_hs_s  = bready_q  & m_bvalid;
  assign ar_hs_s = arvalid_q & m_arready;
  assign r_hs_s  = rready_q  & m_rvalid;

  // Next-state and next-output logic for the bridge FSM.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ready_d   = 1'b0;

    case (state_q)
      RB2AXI_IDLE: begin
        if (reg_addr_valid) begin
          if (reg_write) begin
            awaddr_d  = reg_addr & ALIGN_MASK;
            wdata_d   = reg_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = RB2AXI_WR_REQ;
          end else begin
            araddr_d  = reg_addr & ALIGN_MASK;
            arvalid_d = 1'b1;
            state_d   = RB2AXI_RD_REQ;
          end
        end else begin
          state_d = RB2AXI_IDLE;
        end
      end

      RB2AXI_WR_REQ: begin
        // AW and W complete independently; the flags remember which is done.
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end else begin
          wvalid_d = wvalid_q;
        end
        if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) begin
          bready_d = 1'b1;
          state_d  = RB2AXI_WR_RESP;
        end else begin
          state_d  = RB2AXI_WR_REQ;
        end
      end

      RB2AXI_WR_RESP: begin
        if (b_hs_s) begin
          bready_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = axi_resp_is_err(m_bresp);
          ready_d   = 1'b1;
          state_d   = RB2AXI_DONE;
        end else begin
          state_d   = RB2AXI_WR_RESP;
        end
      end

      RB2AXI_RD_REQ: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RB2AXI_RD_RESP;
        end else begin
          state_d   = RB2AXI_RD_REQ;
        end
      end

      RB2AXI_RD_RESP: begin
        // Read data is captured even when the response is an error.
        if (r_hs_s) begin
          rready_d = 1'b0;
          rdata_d  = m_rdata;
          err_d    = axi_resp_is_err(m_rresp);
          ready_d  = 1'b1;
          state_d  = RB2AXI_DONE;
        end else begin
          state_d  = RB2AXI_RD_RESP;
        end
      end

      RB2AXI_DONE: begin
        // reg_ready is high in this state; the requester drops its request now.
        state_d = RB2AXI_IDLE;
      end

      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = RB2AXI_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q   <= RB2AXI_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= {ADDR_WIDTH{1'b0}};
      araddr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      rdata_q   <= {DATA_WIDTH{1'b0}};
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ready = ready_q;
  assign reg_err   = err_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = awaddr_q;
  assign m_awprot  = 3'b000;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = {(DATA_WIDTH/8){1'b1}};
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = araddr_q;
  assign m_arprot  = 3'b000;
  assign m_rready  = rready_q;

endmodule : regbus2axi4lite

// File: tb/tb_regbus2axi4lite.sv
// tb_regbus2axi4lite
// Directed bench for regbus2axi4lite. A configurable AXI4-lite slave model
// (per-channel wait counts, response codes, read data) runs on the falling
// edge; the requester drives and samples 2 time units after the rising edge.
module tb_regbus2axi4lite;

  logic        Clk = 1'b0;
  logic        RESET = 1'b1;
  logic        reg_addr_valid = 1'b0;
  logic        reg_write = 1'b0;
  logic [31:0] reg_addr = 32'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        reg_err;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [31:0] m_rdata = 32'h0;
  logic [1:0]  m_rresp = 2'b00;

  regbus2axi4lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .RESET(RESET),
    .reg_addr_valid(reg_addr_valid), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ready(reg_ready), .reg_err(reg_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Slave configuration (written by the requester between accesses).
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  // Slave observations.
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, r_hs_cyc = 0, bready_first = -1;
  int          awvalid_cycles = 0, wvalid_cycles = 0, ready_n = 0, bready_early = 0;
  logic [31:0] aw_addr_seen = 32'h0, w_data_seen = 32'h0, ar_addr_seen = 32'h0;
  logic [3:0]  w_strb_seen = 4'h0;

  // AXI4-lite slave model.
  always @(negedge Clk) begin
    if (RESET) begin
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
    end else begin
      if (reg_ready) ready_n++;
      if (m_awvalid) awvalid_cycles++;
      if (m_wvalid) wvalid_cycles++;
      if (m_bready && bready_first < 0) bready_first = cyc;
      if (m_bready && !(aw_hs_n > b_hs_n && w_hs_n > b_hs_n)) bready_early++;
      // B channel: respond only once both AW and W have completed.
      if (aw_hs_n > b_hs_n && w_hs_n > b_hs_n) begin
        m_bresp = cfg_bresp;
        if (b_cnt >= b_wait) m_bvalid = 1'b1;
        else begin m_bvalid = 1'b0; b_cnt++; end
        if (m_bvalid && m_bready) begin b_hs_n++; b_cnt = 0; end
      end else begin
        m_bvalid = 1'b0; b_cnt = 0;
      end
      // R channel.
      if (ar_hs_n > r_hs_n) begin
        m_rresp = cfg_rresp; m_rdata = cfg_rdata;
        if (r_cnt >= r_wait) m_rvalid = 1'b1;
        else begin m_rvalid = 1'b0; r_cnt++; end
        if (m_rvalid && m_rready) begin r_hs_n++; r_hs_cyc = cyc; r_cnt = 0; end
      end else begin
        m_rvalid = 1'b0; r_cnt = 0;
      end
      // AW channel.
      if (m_awvalid) begin
        if (aw_cnt >= aw_wait) m_awready = 1'b1;
        else begin m_awready = 1'b0; aw_cnt++; end
      end else begin
        m_awready = 1'b0; aw_cnt = 0;
      end
      if (m_awvalid && m_awready) begin
        aw_hs_n++; aw_hs_cyc = cyc; aw_addr_seen = m_awaddr; aw_cnt = 0;
      end
      // W channel.
      if (m_wvalid) begin
        if (w_cnt >= w_wait) m_wready = 1'b1;
        else begin m_wready = 1'b0; w_cnt++; end
      end else begin
        m_wready = 1'b0; w_cnt = 0;
      end
      if (m_wvalid && m_wready) begin
        w_hs_n++; w_hs_cyc = cyc; w_data_seen = m_wdata; w_strb_seen = m_wstrb; w_cnt = 0;
      end
      // AR channel.
      if (m_arvalid) begin
        if (ar_cnt >= ar_wait) m_arready = 1'b1;
        else begin m_arready = 1'b0; ar_cnt++; end
      end else begin
        m_arready = 1'b0; ar_cnt = 0;
      end
      if (m_arvalid && m_arready) begin
        ar_hs_n++; ar_addr_seen = m_araddr; ar_cnt = 0;
      end
    end
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_awvalid"}, 64'(m_awvalid), 64'd0);
    check_eq({tag, "_wvalid"},  64'(m_wvalid),  64'd0);
    check_eq({tag, "_bready"},  64'(m_bready),  64'd0);
    check_eq({tag, "_arvalid"}, 64'(m_arvalid), 64'd0);
    check_eq({tag, "_rready"},  64'(m_rready),  64'd0);
    check_eq({tag, "_ready"},   64'(reg_ready), 64'd0);
    check_eq({tag, "_err"},     64'(reg_err),   64'd0);
    check_eq({tag, "_rdata"},   64'(reg_rdata), 64'd0);
    check_eq({tag, "_awaddr"},  64'(m_awaddr),  64'd0);
    check_eq({tag, "_araddr"},  64'(m_araddr),  64'd0);
    check_eq({tag, "_wdata"},   64'(m_wdata),   64'd0);
  endtask

  task automatic clear_stats();
    awvalid_cycles = 0; wvalid_cycles = 0; bready_first = -1; ready_n = 0;
  endtask

  // One regbus access; returns the cycles from request to reg_ready.
  task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat);
    int req_cyc;
    logic got;
    clear_stats();
    reg_write = wr; reg_addr = addr; reg_wdata = wd; reg_addr_valid = 1'b1;
    req_cyc = cyc;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #2;
      if (reg_ready) begin got = 1'b1; break; end
    end
    reg_addr_valid = 1'b0;
    lat = cyc - req_cyc;
    check_eq({tag, "_ready_seen"}, 64'(got), 64'd1);
  endtask

  int lat;

  initial begin
    // Reset.
    RESET = 1'b1;
    repeat (3) @(posedge Clk);
    #2 RESET = 1'b0;
    check_idle_outputs("rst");
    check_eq("rst_awprot", 64'(m_awprot), 64'd0);

    // Write 0x4 <- 1, zero-wait slave.
    access("wr0", 1'b1, 32'h0000_0004, 32'h0000_0001, lat);
    check_eq("wr0_latency", 64'(lat), 64'd3);
    check_eq("wr0_awaddr", 64'(aw_addr_seen), 64'h4);
    check_eq("wr0_wdata", 64'(w_data_seen), 64'h1);
    check_eq("wr0_wstrb", 64'(w_strb_seen), 64'hF);
    check_eq("wr0_err", 64'(reg_err), 64'd0);
    @(posedge Clk); #2;
    check_eq("wr0_ready_pulse_len", 64'(reg_ready), 64'd0);

    // Read 0x8, four wait cycles on rvalid.
    r_wait = 4; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
    access("rd0", 1'b0, 32'h0000_0008, 32'h0, lat);
    check_eq("rd0_latency", 64'(lat), 64'd7);
    check_eq("rd0_ready_after_r", 64'(cyc), 64'(r_hs_cyc + 1));
    check_eq("rd0_araddr", 64'(ar_addr_seen), 64'h8);
    check_eq("rd0_rdata", 64'(reg_rdata), 64'h1234_5678);
    check_eq("rd0_err", 64'(reg_err), 64'd0);
    r_wait = 0;

    // Write where W completes three cycles before AW.
    @(posedge Clk); #2;
    aw_wait = 3; w_wait = 0;
    access("wr1", 1'b1, 32'h0000_000C, 32'hA5A5_0003, lat);
    check_eq("wr1_latency", 64'(lat), 64'd6);
    check_eq("wr1_w_before_aw", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
    check_eq("wr1_wvalid_cycles", 64'(wvalid_cycles), 64'd1);
    check_eq("wr1_awvalid_cycles", 64'(awvalid_cycles), 64'd4);
    check_eq("wr1_bready_first", 64'(bready_first), 64'(aw_hs_cyc + 1));
    repeat (4) @(posedge Clk); #2;
    check_eq("wr1_single_ready", 64'(ready_n), 64'd1);
    check_eq("wr1_rdata_held", 64'(reg_rdata), 64'h1234_5678);
    aw_wait = 0;

    // Unaligned write and read.
    access("wr2", 1'b1, 32'h0000_0006, 32'h0000_0066, lat);
    check_eq("wr2_awaddr_aligned", 64'(aw_addr_seen), 64'h4);
    cfg_rdata = 32'h0BAD_F00D;
    access("rd1", 1'b0, 32'h0000_000B, 32'h0, lat);
    check_eq("rd1_araddr_aligned", 64'(ar_addr_seen), 64'h8);
    check_eq("rd1_rdata", 64'(reg_rdata), 64'h0BAD_F00D);

    // SLVERR read, then an OKAY write clears the error.
    cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b10;
    access("rd2", 1'b0, 32'h0000_0010, 32'h0, lat);
    check_eq("rd2_err", 64'(reg_err), 64'd1);
    check_eq("rd2_rdata", 64'(reg_rdata), 64'hDEAD_BEEF);
    cfg_rresp = 2'b00;
    access("wr3", 1'b1, 32'h0000_0010, 32'h0000_0005, lat);
    check_eq("wr3_err_cleared", 64'(reg_err), 64'd0);

    // DECERR write response sets the error flag.
    cfg_bresp = 2'b11;
    access("wr4", 1'b1, 32'h0000_0014, 32'h0000_0007, lat);
    check_eq("wr4_err", 64'(reg_err), 64'd1);
    cfg_bresp = 2'b00;

    // Reset while waiting in WR_RESP with bvalid low.
    @(posedge Clk); #2;
    b_wait = 20;
    clear_stats();
    reg_write = 1'b1; reg_addr = 32'h0000_0018; reg_wdata = 32'h0000_0009; reg_addr_valid = 1'b1;
    repeat (3) @(posedge Clk); #2;
    check_eq("rst2_in_wr_resp", 64'(m_bready), 64'd1);
    check_eq("rst2_bvalid_low", 64'(m_bvalid), 64'd0);
    RESET = 1'b1; reg_addr_valid = 1'b0;
    @(posedge Clk); #2;
    RESET = 1'b0;
    check_idle_outputs("rst2");
    repeat (3) @(posedge Clk); #2;
    check_eq("rst2_no_ready", 64'(ready_n), 64'd0);
    b_wait = 0;

    // Read after reset completes normally.
    cfg_rdata = 32'hA5A5_5A5A;
    access("rd3", 1'b0, 32'h0000_0020, 32'h0, lat);
    check_eq("rd3_latency", 64'(lat), 64'd3);
    check_eq("rd3_araddr", 64'(ar_addr_seen), 64'h20);
    check_eq("rd3_rdata", 64'(reg_rdata), 64'hA5A5_5A5A);
    check_eq("rd3_err", 64'(reg_err), 64'd0);

    check_eq("bready_before_aw_w", 64'(bready_early), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule : tb_regbus2axi4lite
